// File: rtl/operand_fetch_pkg.sv
// Shared widths for the operand-fetch stage; instances may override them.
package operand_fetch_pkg;
  localparam int OF_DATA_W = 32;
  localparam int OF_ADDR_W = 5;
  localparam int OF_CTRL_W = 8;
  localparam int NUM_REGS  = 2 ** OF_ADDR_W;
endpackage

// File: rtl/operand_fetch_regfile.sv
// 2-read/1-write register file with hard-wired zero register and sync reset.
// Reads are combinational; writes land on posedge; reset wins over a write.
module regfile_2r1w
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = OF_DATA_W,
  parameter int ADDR_W = OF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads rs/rt with write-back bypass into a one-entry output buffer.
// Latency 1, 1 req/cycle; in_ready = !out_valid || out_ready, held operands track write-back.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = OF_DATA_W,
  parameter int ADDR_W = OF_ADDR_W,
  parameter int CTRL_W = OF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [CTRL_W-1:0] out_ctrl
);
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [ADDR_W-1:0] held_rs;
  logic [ADDR_W-1:0] held_rt;
  logic              accept;
  logic              hold;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (in_rs),
    .ra_data (rf_a),
    .rb_addr (in_rt),
    .rb_data (rf_b),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hold     = out_valid && !out_ready;

  // Same-cycle write-back is not yet visible in the array, so forward it.
  assign fwd_a = (wb_en && wb_addr == in_rs && in_rs != '0) ? wb_data : rf_a;
  assign fwd_b = (wb_en && wb_addr == in_rt && in_rt != '0) ? wb_data : rf_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_ctrl  <= '0;
      held_rs   <= '0;
      held_rt   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= fwd_a;
      out_b     <= fwd_b;
      out_ctrl  <= in_ctrl;
      held_rs   <= in_rs;
      held_rt   <= in_rt;
    end else if (hold) begin
      // A stalled entry must not go stale when its source is rewritten.
      if (wb_en && wb_addr == held_rs && held_rs != '0) out_a <= wb_data;
      if (wb_en && wb_addr == held_rt && held_rt != '0) out_b <= wb_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
